// File: rtl/mgt_01_fp_sqrt_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mgt_01_fp_sqrt_issue_ctrl
// Brief   : FP32 sqrt issue/sequencing: resolves special operands locally,
//           drives the sqrt unit under a watchdog, hands result to writeback.
// Revision: 1.0
// ============================================================================
module mgt_01_fp_sqrt_issue_ctrl #(
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_radicand_i,
    input  logic [4:0]  req_rd_i,
    output logic [31:0] sqrt_radicand_o,
    output logic        sqrt_clk_en_o,
    input  logic [31:0] sqrt_root_i,
    input  logic        sqrt_valid_i,
    input  logic        sqrt_invalid_op_i,
    input  logic        sqrt_overflow_i,
    input  logic        sqrt_underflow_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [31:0] wb_result_o,
    output logic [4:0]  wb_rd_o,
    output logic [4:0]  wb_fflags_o,
    output logic        timeout_o
);

    localparam int               CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0]      C_QNAN     = 32'h7FC0_0000;
    localparam logic [4:0]       C_FFLAG_NV = 5'b10000;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_radicand;
    logic [31:0]      r_result;
    logic [4:0]       r_rd;
    logic [4:0]       r_fflags;
    logic             r_timeout;

    logic             w_accept;
    logic             w_unit_done;
    logic             w_timeout;
    logic             w_special;
    logic [31:0]      w_fast_result;
    logic [4:0]       w_fast_fflags;
    logic             w_sign;
    logic [7:0]       w_exp;
    logic [22:0]      w_frac;

    assign w_sign = req_radicand_i[31];
    assign w_exp  = req_radicand_i[30:23];
    assign w_frac = req_radicand_i[22:0];

    // NaNs are checked before the sign so a negative quiet NaN stays flag-free.
    always_comb begin
        w_special     = 1'b1;
        w_fast_result = C_QNAN;
        w_fast_fflags = 5'b0;
        if (w_exp == 8'hFF && w_frac != 23'd0) begin
            w_fast_fflags = w_frac[22] ? 5'b0 : C_FFLAG_NV;
        end else if (w_exp == 8'd0 && w_frac == 23'd0) begin
            w_fast_result = req_radicand_i;
        end else if (w_sign) begin
            w_fast_fflags = C_FFLAG_NV;
        end else if (w_exp == 8'hFF) begin
            w_fast_result = req_radicand_i;
        end else begin
            w_special = 1'b0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_unit_done  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) begin
                    w_accept     = 1'b1;
                    w_next_state = w_special ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (sqrt_valid_i) begin
                    w_unit_done  = 1'b1;
                    w_next_state = ST_DONE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (wb_ready_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
        // Flush overrides every transition and suppresses all side effects.
        if (flush_i) begin
            w_next_state = ST_IDLE;
            w_accept     = 1'b0;
            w_unit_done  = 1'b0;
            w_timeout    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_radicand <= 32'd0;
            r_result   <= 32'd0;
            r_rd       <= 5'd0;
            r_fflags   <= 5'd0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_timeout <= w_timeout;
            if (w_accept) begin
                r_radicand <= req_radicand_i;
                r_rd       <= req_rd_i;
                r_cnt      <= '0;
                if (w_special) begin
                    r_result <= w_fast_result;
                    r_fflags <= w_fast_fflags;
                end
            end else if (r_state == ST_BUSY && r_cnt != '1) begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
            if (w_unit_done) begin
                r_result <= sqrt_root_i;
                r_fflags <= {sqrt_invalid_op_i, 1'b0, sqrt_overflow_i, sqrt_underflow_i, 1'b0};
            end
            if (w_timeout) begin
                r_result <= C_QNAN;
                r_fflags <= C_FFLAG_NV;
            end
        end
    end

    // Enables decode straight from the state register so reset drops them at once.
    assign req_ready_o     = (r_state == ST_IDLE);
    assign sqrt_clk_en_o   = (r_state == ST_BUSY);
    assign wb_valid_o      = (r_state == ST_DONE);
    assign sqrt_radicand_o = r_radicand;
    assign wb_result_o     = r_result;
    assign wb_rd_o         = r_rd;
    assign wb_fflags_o     = r_fflags;
    assign timeout_o       = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mgt_01_fp_sqrt_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mgt_01_fp_sqrt_issue_ctrl
// Brief   : Directed and randomized bench with a behavioural sqrt-issue model.
// Revision: 1.0
// ============================================================================
module tb_mgt_01_fp_sqrt_issue_ctrl;

    localparam int          TIMEOUT_CYCLES = 40;
    localparam logic [31:0] C_QNAN         = 32'h7FC0_0000;
    localparam logic [4:0]  C_NV           = 5'b10000;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_radicand_i = 32'd0;
    logic [4:0]  req_rd_i = 5'd0;
    logic [31:0] sqrt_radicand_o;
    logic        sqrt_clk_en_o;
    logic [31:0] sqrt_root_i = 32'd0;
    logic        sqrt_valid_i = 1'b0;
    logic        sqrt_invalid_op_i = 1'b0;
    logic        sqrt_overflow_i = 1'b0;
    logic        sqrt_underflow_i = 1'b0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [31:0] wb_result_o;
    logic [4:0]  wb_rd_o;
    logic [4:0]  wb_fflags_o;
    logic        timeout_o;

    int n_tests = 0;
    int n_fail  = 0;

    mgt_01_fp_sqrt_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .flush_i           (flush_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_radicand_i    (req_radicand_i),
        .req_rd_i          (req_rd_i),
        .sqrt_radicand_o   (sqrt_radicand_o),
        .sqrt_clk_en_o     (sqrt_clk_en_o),
        .sqrt_root_i       (sqrt_root_i),
        .sqrt_valid_i      (sqrt_valid_i),
        .sqrt_invalid_op_i (sqrt_invalid_op_i),
        .sqrt_overflow_i   (sqrt_overflow_i),
        .sqrt_underflow_i  (sqrt_underflow_i),
        .wb_valid_o        (wb_valid_o),
        .wb_ready_i        (wb_ready_i),
        .wb_result_o       (wb_result_o),
        .wb_rd_o           (wb_rd_o),
        .wb_fflags_o       (wb_fflags_o),
        .timeout_o         (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got stuck expected completion");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Behavioural IEEE-754 classification of sqrt special cases.
    function automatic void ref_fast(input logic [31:0] a, output bit special,
                                     output logic [31:0] res, output logic [4:0] ff);
        int unsigned e   = (a >> 23) & 32'hFF;
        int unsigned f   = a & 32'h007F_FFFF;
        bit          neg = a[31];
        special = 1'b1;
        res     = C_QNAN;
        ff      = 5'd0;
        if (e == 255 && f != 0)      ff  = (f >= 32'h0040_0000) ? 5'd0 : C_NV;
        else if (e == 0 && f == 0)   res = a;
        else if (neg)                ff  = C_NV;
        else if (e == 255)           res = a;
        else                         special = 1'b0;
    endfunction

    task automatic check_reset_values(input string where);
        check({where, "_req_ready"}, req_ready_o, 1);
        check({where, "_clk_en"}, sqrt_clk_en_o, 0);
        check({where, "_radicand"}, sqrt_radicand_o, 0);
        check({where, "_wb_valid"}, wb_valid_o, 0);
        check({where, "_wb_result"}, wb_result_o, 0);
        check({where, "_wb_rd"}, wb_rd_o, 0);
        check({where, "_wb_fflags"}, wb_fflags_o, 0);
        check({where, "_timeout"}, timeout_o, 0);
    endtask

    // One complete operation; lat = cycle of BUSY in which the unit answers.
    task automatic run_op(input logic [31:0] a, input logic [4:0] rd, input int lat,
                          input logic [31:0] root, input logic [2:0] uflags, input int stall);
        bit          special;
        logic [31:0] exp_res;
        logic [4:0]  exp_ff;
        bit          exp_to;
        int          n_busy;
        ref_fast(a, special, exp_res, exp_ff);
        exp_to = 1'b0;
        if (!special) begin
            if (lat <= TIMEOUT_CYCLES) begin
                exp_res = root;
                exp_ff  = {uflags[2], 1'b0, uflags[1], uflags[0], 1'b0};
            end else begin
                exp_res = C_QNAN;
                exp_ff  = C_NV;
                exp_to  = 1'b1;
            end
        end
        check("idle_ready", req_ready_o, 1);
        req_valid_i    = 1'b1;
        req_radicand_i = a;
        req_rd_i       = rd;
        tick();
        req_valid_i    = 1'b0;
        req_radicand_i = $urandom();
        req_rd_i       = 5'($urandom());
        if (!special) begin
            n_busy = exp_to ? TIMEOUT_CYCLES : lat;
            for (int k = 1; k <= n_busy; k++) begin
                check("busy_clk_en", sqrt_clk_en_o, 1);
                check("busy_radicand", sqrt_radicand_o, a);
                check("busy_no_wb", wb_valid_o, 0);
                check("busy_not_ready", req_ready_o, 0);
                if (k == lat) begin
                    sqrt_valid_i      = 1'b1;
                    sqrt_root_i       = root;
                    sqrt_invalid_op_i = uflags[2];
                    sqrt_overflow_i   = uflags[1];
                    sqrt_underflow_i  = uflags[0];
                end
                tick();
                sqrt_valid_i = 1'b0;
                sqrt_root_i  = $urandom();
                {sqrt_invalid_op_i, sqrt_overflow_i, sqrt_underflow_i} = 3'($urandom());
            end
        end else begin
            check("fast_clk_en", sqrt_clk_en_o, 0);
        end
        check("wb_valid", wb_valid_o, 1);
        check("done_clk_en", sqrt_clk_en_o, 0);
        check("wb_result", wb_result_o, exp_res);
        check("wb_rd", wb_rd_o, rd);
        check("wb_fflags", wb_fflags_o, exp_ff);
        check("timeout_pulse", timeout_o, exp_to);
        check("done_not_ready", req_ready_o, 0);
        for (int s = 0; s < stall; s++) begin
            wb_ready_i     = 1'b0;
            req_valid_i    = 1'b1;
            req_radicand_i = $urandom();
            sqrt_valid_i   = 1'($urandom_range(0, 1));
            sqrt_root_i    = $urandom();
            tick();
            check("stall_wb_valid", wb_valid_o, 1);
            check("stall_result", wb_result_o, exp_res);
            check("stall_rd", wb_rd_o, rd);
            check("stall_fflags", wb_fflags_o, exp_ff);
            check("stall_timeout", timeout_o, 0);
            check("stall_not_ready", req_ready_o, 0);
            check("stall_radicand", sqrt_radicand_o, a);
            check("stall_clk_en", sqrt_clk_en_o, 0);
        end
        // Request stays asserted across the handshake edge: it must not be taken there.
        sqrt_valid_i   = 1'b0;
        wb_ready_i     = 1'b1;
        req_valid_i    = 1'b1;
        req_radicand_i = 32'h4000_0000;
        tick();
        wb_ready_i  = 1'b0;
        req_valid_i = 1'b0;
        check("post_wb_valid", wb_valid_o, 0);
        check("post_ready", req_ready_o, 1);
        check("post_clk_en", sqrt_clk_en_o, 0);
        check("post_timeout", timeout_o, 0);
        check("post_radicand", sqrt_radicand_o, a);
    endtask

    // Accept a unit-path op, flush in BUSY cycle at_k, then a stray unit valid.
    task automatic flush_busy(input logic [31:0] a, input int at_k);
        check("fl_idle_ready", req_ready_o, 1);
        req_valid_i    = 1'b1;
        req_radicand_i = a;
        req_rd_i       = 5'd11;
        tick();
        req_valid_i = 1'b0;
        for (int k = 1; k <= at_k; k++) begin
            check("fl_busy_clk_en", sqrt_clk_en_o, 1);
            if (k == at_k) flush_i = 1'b1;
            tick();
        end
        flush_i = 1'b0;
        check("fl_ready", req_ready_o, 1);
        check("fl_clk_en", sqrt_clk_en_o, 0);
        check("fl_wb_valid", wb_valid_o, 0);
        check("fl_timeout", timeout_o, 0);
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) begin
                sqrt_valid_i = 1'b1;
                sqrt_root_i  = 32'h3FB5_04F3;
            end
            tick();
            sqrt_valid_i = 1'b0;
            check("fl_stray_wb_valid", wb_valid_o, 0);
            check("fl_stray_clk_en", sqrt_clk_en_o, 0);
            check("fl_stray_ready", req_ready_o, 1);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int unsigned cat;
        v   = $urandom();
        cat = $urandom_range(0, 11);
        case (cat)
            0: v = 32'h0000_0000;
            1: v = 32'h8000_0000;
            2: v = 32'h7F80_0000;
            3: v = 32'hFF80_0000;
            4: v = {v[31], 8'hFF, 1'b1, v[21:0]};
            5: v = {v[31], 8'hFF, 1'b0, v[21:1], 1'b1};
            6: v = {1'b1, v[30:1], 1'b1};
            default: begin
                v[31] = 1'b0;
                if (v[30:23] == 8'hFF) v[30:23] = 8'h7F;
                if (v[30:0] == 31'd0) v[0] = 1'b1;
            end
        endcase
        return v;
    endfunction

    initial begin
        #1 rst_n_i = 1'b0;
        #1 check_reset_values("rst");
        tick();
        tick();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        check_reset_values("after_rst");

        run_op(32'h4000_0000, 5'd5, 28, 32'h3FB5_04F3, 3'b000, 0);

        run_op(32'hC000_0000, 5'd1, 0, 32'd0, 3'b000, 0);
        run_op(32'h8000_0000, 5'd2, 0, 32'd0, 3'b000, 0);
        run_op(32'h7F80_0000, 5'd3, 0, 32'd0, 3'b000, 0);
        run_op(32'h7FA0_0000, 5'd4, 0, 32'd0, 3'b000, 0);
        run_op(32'h7FC0_0001, 5'd6, 0, 32'd0, 3'b000, 0);
        run_op(32'h0000_0000, 5'd7, 0, 32'd0, 3'b000, 0);
        run_op(32'h0000_0001, 5'd8, 3, 32'h1A35_04F3, 3'b001, 0);

        run_op(32'h4080_0000, 5'd9, 10, 32'h4000_0000, 3'b010, 5);
        run_op(32'hFF80_0000, 5'd10, 0, 32'd0, 3'b000, 5);

        flush_busy(32'h4110_0000, 10);
        run_op(32'h4110_0000, 5'd12, 15, 32'h4040_0000, 3'b000, 1);

        run_op(32'h3F80_0000, 5'd13, 1000, 32'h3F80_0000, 3'b000, 2);
        run_op(32'h3F80_0000, 5'd14, TIMEOUT_CYCLES, 32'h3F80_0000, 3'b100, 0);
        run_op(32'h3F80_0000, 5'd15, TIMEOUT_CYCLES + 1, 32'h3F80_0000, 3'b000, 0);
        run_op(32'h3F80_0000, 5'd16, 1, 32'h3F80_0000, 3'b111, 0);

        flush_busy(32'h4200_0000, TIMEOUT_CYCLES);

        // Flush in IDLE with a simultaneous request: nothing is accepted.
        flush_i        = 1'b1;
        req_valid_i    = 1'b1;
        req_radicand_i = 32'h4300_0000;
        tick();
        flush_i     = 1'b0;
        req_valid_i = 1'b0;
        check("fl_idle_ready", req_ready_o, 1);
        check("fl_idle_clk_en", sqrt_clk_en_o, 0);
        check("fl_idle_wb_valid", wb_valid_o, 0);
        check("fl_idle_radicand", sqrt_radicand_o, 32'h4200_0000);

        // Flush together with wb_ready in DONE.
        req_valid_i    = 1'b1;
        req_radicand_i = 32'h8000_0000;
        tick();
        req_valid_i = 1'b0;
        check("fl_done_wb_valid_pre", wb_valid_o, 1);
        flush_i    = 1'b1;
        wb_ready_i = 1'b1;
        tick();
        flush_i    = 1'b0;
        wb_ready_i = 1'b0;
        check("fl_done_wb_valid", wb_valid_o, 0);
        check("fl_done_ready", req_ready_o, 1);

        // Asynchronous reset in the middle of BUSY.
        req_valid_i    = 1'b1;
        req_radicand_i = 32'h4000_0000;
        req_rd_i       = 5'd17;
        tick();
        req_valid_i = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("pre_rst_clk_en", sqrt_clk_en_o, 1);
        #2 rst_n_i = 1'b0;
        #1 check_reset_values("mid_rst");
        tick();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick();
        run_op(32'h4522_5AFB, 5'd18, 20, 32'h424B_DEB9, 3'b000, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(rand_operand(), 5'($urandom()), int'($urandom_range(1, 45)),
                   $urandom(), 3'($urandom()), int'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
